pipe_skid_stage: RTL and testbench

- Parametrised, elastic replacement for the fixed fetch/decode/execute/memory/writeback pipeline registers.
- One instance sits between each pair of pipeline stages and carries that stage's packed control and data bundle.
- Provides a valid/ready handshake and a 2-entry skid buffer, so the ready path is fully registered.
- Adds synchronous flush with bubble (NOP) insertion and a saturating stall-cycle counter. The old registers offered only a write-enable and had no reset.

---
 rtl/pipe_pkg.sv | 45 ++++
 rtl/pipe_sat_counter.sv | 22 ++
 rtl/pipe_skid_stage.sv | 103 ++++++++++
 tb/tb_pipe_skid_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage registers: FSM state encoding,
// the NOP bubble value, and the per-stage payload bundles.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam logic [31:0] RV_NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        reg_wr;
  } mem_wb_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register: valid/ready handshake with a 2-entry skid buffer,
// flush-to-bubble and a saturating stall counter.
//
//   state    | meaning
//   ST_EMPTY | nothing held, out_data = BUBBLE, in_ready = 1
//   ST_ONE   | main register valid, skid empty, in_ready = 1
//   ST_FULL  | main and skid valid, in_ready = 0
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter logic [31:0] BUBBLE = RV_NOP,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  input  logic             clr_stats,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [WIDTH-1:0] BUBBLE_W = WIDTH'(BUBBLE);

  pipe_state_e      state;
  logic [WIDTH-1:0] skid_data;
  logic             accept;
  logic             pop;

  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign occupancy = state;

  // in_ready and out_valid are kept as flops so no combinational path
  // crosses the stage in either direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      out_data  <= BUBBLE_W;
      skid_data <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (flush) begin
      state     <= ST_EMPTY;
      out_data  <= BUBBLE_W;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state     <= ST_ONE;
            out_data  <= in_data;
            out_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            out_data <= in_data;
          end else if (accept) begin
            state     <= ST_FULL;
            skid_data <= in_data;
            in_ready  <= 1'b0;
          end else if (pop) begin
            state     <= ST_EMPTY;
            out_data  <= BUBBLE_W;
            out_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state    <= ST_ONE;
            out_data <= skid_data;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_data  <= BUBBLE_W;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid & ~out_ready & ~flush),
    .clr   (clr_stats),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: a default instance plus a CNT_W=4
// instance sharing the same stimulus for the saturation scenario.
module tb_pipe_skid_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        flush;
  logic        clr_stats;

  logic        in_ready,  out_valid;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_data;
  logic [1:0]  s_occupancy;
  logic [3:0]  s_stall_cnt;

  int vectors;
  int miscompares;

  pipe_skid_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .clr_stats (clr_stats),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  pipe_skid_stage #(.CNT_W(4)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_data   (in_data),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_data  (s_out_data),
    .flush     (flush),
    .clr_stats (clr_stats),
    .occupancy (s_occupancy),
    .stall_cnt (s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid  = i[0];
      in_data   = 32'hDEAD0000 + i;
      out_ready = i[1];
      flush     = i[0];
      clr_stats = ~i[0];
      #5;
    end
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0; clr_stats = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    vectors++;
    if (out_data !== 32'h00000013) begin miscompares++; $display("FAIL reset_out_data got %h want 00000013", out_data); end
    vectors++;
    if (occupancy !== 2'd0) begin miscompares++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
    vectors++;
    if (stall_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
  endtask

  task automatic test_streaming();
    logic [31:0] seq [3];
    seq[0] = 32'h11; seq[1] = 32'h22; seq[2] = 32'h33;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = seq[i];
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== seq[i]) begin
        miscompares++;
        $display("FAIL stream_beat%0d got v=%0b d=%h want v=1 d=%h", i, out_valid, out_data, seq[i]);
      end
      vectors++;
      if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_occ%0d got occ=%0d rdy=%0b want occ=1 rdy=1", i, occupancy, in_ready);
      end
    end
    in_valid = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 32'h13 || occupancy !== 2'd0) begin
      miscompares++;
      $display("FAIL stream_drain got v=%0b d=%h occ=%0d want v=0 d=00000013 occ=0", out_valid, out_data, occupancy);
    end
  endtask

  task automatic test_backpressure();
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 32'hA0;
    step();
    in_data = 32'hA1;
    step();
    vectors++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA0) begin
      miscompares++;
      $display("FAIL skid_full got occ=%0d rdy=%0b d=%h want occ=2 rdy=0 d=000000a0", occupancy, in_ready, out_data);
    end
    in_data = 32'hA2;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (out_data !== 32'hA0 || out_valid !== 1'b1 || occupancy !== 2'd2) begin
        miscompares++;
        $display("FAIL skid_hold%0d got d=%h v=%0b occ=%0d want d=000000a0 v=1 occ=2", i, out_data, out_valid, occupancy);
      end
    end
    out_ready = 1'b1;
    step();
    vectors++;
    if (out_data !== 32'hA1 || in_ready !== 1'b1 || occupancy !== 2'd1) begin
      miscompares++;
      $display("FAIL skid_pop1 got d=%h rdy=%0b occ=%0d want d=000000a1 rdy=1 occ=1", out_data, in_ready, occupancy);
    end
    step();
    vectors++;
    if (out_data !== 32'hA2 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL skid_pop2 got d=%h v=%0b want d=000000a2 v=1", out_data, out_valid);
    end
    in_valid = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 32'h13) begin
      miscompares++;
      $display("FAIL skid_drain got v=%0b d=%h want v=0 d=00000013", out_valid, out_data);
    end
    vectors++;
    if (stall_cnt !== 16'd3) begin miscompares++; $display("FAIL skid_stall_cnt got %0d want 3", stall_cnt); end
  endtask

  task automatic test_flush_full();
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 32'hB0;
    step();
    in_data = 32'hB1;
    step();
    vectors++;
    if (occupancy !== 2'd2) begin miscompares++; $display("FAIL flush_prefill got occ=%0d want 2", occupancy); end
    flush   = 1'b1;
    in_data = 32'hB2;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 32'h13 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_state got v=%0b d=%h occ=%0d rdy=%0b want v=0 d=00000013 occ=0 rdy=1",
               out_valid, out_data, occupancy, in_ready);
    end
    vectors++;
    if (stall_cnt !== 16'd4) begin miscompares++; $display("FAIL flush_stall_cnt got %0d want 4", stall_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (out_valid !== 1'b0 || out_data !== 32'h13) begin
        miscompares++;
        $display("FAIL flush_no_leak%0d got v=%0b d=%h want v=0 d=00000013", i, out_valid, out_data);
      end
    end
  endtask

  task automatic test_async_reset();
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 32'hC0;
    step();
    in_data = 32'hC1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    vectors++;
    if (occupancy !== 2'd2 || stall_cnt !== 16'd5) begin
      miscompares++;
      $display("FAIL areset_pre got occ=%0d cnt=%0d want occ=2 cnt=5", occupancy, stall_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h13 ||
        occupancy !== 2'd0 || stall_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL areset_immediate got v=%0b rdy=%0b d=%h occ=%0d cnt=%0d want v=0 rdy=1 d=00000013 occ=0 cnt=0",
               out_valid, in_ready, out_data, occupancy, stall_cnt);
    end
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    vectors++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      miscompares++;
      $display("FAIL areset_after got v=%0b occ=%0d want v=0 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_saturation();
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 32'hD0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    vectors++;
    if (s_stall_cnt !== 4'd15) begin miscompares++; $display("FAIL sat_small got %0d want 15", s_stall_cnt); end
    vectors++;
    if (stall_cnt !== 16'd20) begin miscompares++; $display("FAIL sat_wide got %0d want 20", stall_cnt); end
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    vectors++;
    if (s_stall_cnt !== 4'd0 || stall_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL sat_clear got small=%0d wide=%0d want 0 0", s_stall_cnt, stall_cnt);
    end
    step();
    vectors++;
    if (s_stall_cnt !== 4'd1) begin miscompares++; $display("FAIL sat_restart got %0d want 1", s_stall_cnt); end
    out_ready = 1'b1;
    step();
    vectors++;
    if (s_out_valid !== 1'b0 || s_out_data !== 32'h13) begin
      miscompares++;
      $display("FAIL sat_drain got v=%0b d=%h want v=0 d=00000013", s_out_valid, s_out_data);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0; clr_stats = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_full();
    test_async_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
